// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: datapath width, bubble encoding and the
// IF/ID sequencing states.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        WARM = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Bundle of fetch-side inputs and decode-side outputs of the IF/ID register.
// The slave side is the pipeline register; the master side drives fetch and hazards.
interface if_id_stage_if;
    import cpu_pkg::*;

    logic              stall_i;
    logic              flush_i;
    logic [DATA_W-1:0] if_pc;
    logic [DATA_W-1:0] if_pc_add_4;
    logic [DATA_W-1:0] imem_rdata;
    logic              pc_en_o;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_pc_add_4;
    logic [DATA_W-1:0] id_instr;
    logic              hold_busy_o;

    modport master (
        output stall_i, flush_i, if_pc, if_pc_add_4, imem_rdata,
        input  pc_en_o, id_valid, id_pc, id_pc_add_4, id_instr, hold_busy_o
    );

    modport slave (
        input  stall_i, flush_i, if_pc, if_pc_add_4, imem_rdata,
        output pc_en_o, id_valid, id_pc, id_pc_add_4, id_instr, hold_busy_o
    );

endinterface

// File: rtl/if_hold_buf.sv
// One-entry buffer that keeps the instruction word fetched on the first stall
// cycle, since the RAM output drifts to the next address while the PC is frozen.
module if_hold_buf
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] instr_o
);

    logic [DATA_W-1:0] buf_q, buf_d;
    logic              vld_q, vld_d;

    // Clear wins over capture so a flush always discards the held word.
    always_comb begin
        buf_d = buf_q;
        vld_d = vld_q;
        if (clear_i) begin
            vld_d = 1'b0;
        end else if (capture_i) begin
            buf_d = rdata_i;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
            vld_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            vld_q <= vld_d;
        end
    end

    assign instr_o = vld_q ? buf_q : rdata_i;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: owns the PC enable, sequences warm-up, stall-hold
// and flush, and presents {PC, PC+4, instr} to decode one cycle after fetch.
module if_id_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    if_id_stage_if.slave  bus
);

    fetch_state_e      state_q;
    logic              id_valid_q;
    logic [DATA_W-1:0] id_pc_q;
    logic [DATA_W-1:0] id_pc_add_4_q;
    logic [DATA_W-1:0] id_instr_q;

    logic              pc_en;
    logic              capture;
    logic              clear;
    logic [DATA_W-1:0] fetch_word;

    assign pc_en   = ~bus.stall_i | bus.flush_i;
    assign capture = (state_q == RUN) & bus.stall_i & ~bus.flush_i;
    assign clear   = bus.flush_i | ((state_q == HOLD) & ~bus.stall_i);

    if_hold_buf u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .capture_i (capture),
        .clear_i   (clear),
        .rdata_i   (bus.imem_rdata),
        .instr_o   (fetch_word)
    );

    // fetch_word is the held word in HOLD and the live RAM output otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WARM;
            id_valid_q    <= 1'b0;
            id_pc_q       <= '0;
            id_pc_add_4_q <= '0;
            id_instr_q    <= NOP_INSTR;
        end else if (bus.flush_i) begin
            state_q       <= RUN;
            id_valid_q    <= 1'b0;
            id_pc_q       <= bus.if_pc;
            id_pc_add_4_q <= bus.if_pc_add_4;
            id_instr_q    <= NOP_INSTR;
        end else begin
            case (state_q)
                WARM: begin
                    id_valid_q    <= 1'b0;
                    id_pc_q       <= bus.if_pc;
                    id_pc_add_4_q <= bus.if_pc_add_4;
                    id_instr_q    <= NOP_INSTR;
                    if (pc_en) state_q <= RUN;
                end
                RUN: begin
                    if (bus.stall_i) begin
                        state_q <= HOLD;
                    end else begin
                        id_valid_q    <= 1'b1;
                        id_pc_q       <= bus.if_pc;
                        id_pc_add_4_q <= bus.if_pc_add_4;
                        id_instr_q    <= fetch_word;
                    end
                end
                HOLD: begin
                    if (!bus.stall_i) begin
                        state_q       <= RUN;
                        id_valid_q    <= 1'b1;
                        id_pc_q       <= bus.if_pc;
                        id_pc_add_4_q <= bus.if_pc_add_4;
                        id_instr_q    <= fetch_word;
                    end
                end
                default: state_q <= WARM;
            endcase
        end
    end

    assign bus.pc_en_o     = pc_en;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_add_4 = id_pc_add_4_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.hold_busy_o = (state_q == HOLD);

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for the IF/ID register: a fetch unit and synchronous RAM are modelled
// here, and decode contents are predicted from the program image directly.
module tb_if_id_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_id_stage_if bus_if();

    if_id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    logic [31:0] mem [0:255];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        chk_en   = 1'b0;
    logic        primed   = 1'b0;
    logic        e_valid, e_busy;
    logic [31:0] e_pc, e_pc4, e_instr;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        logic pe;
        if (chk_en) begin
            pe = ~bus_if.stall_i | bus_if.flush_i;
            check("pc_en_o", {31'b0, bus_if.pc_en_o}, {31'b0, pe});
            check("id_valid", {31'b0, bus_if.id_valid}, {31'b0, e_valid});
            check("id_pc", bus_if.id_pc, e_pc);
            check("id_pc_add_4", bus_if.id_pc_add_4, e_pc4);
            check("id_instr", bus_if.id_instr, e_instr);
            check("hold_busy_o", {31'b0, bus_if.hold_busy_o}, {31'b0, e_busy});
            if (bus_if.id_valid === 1'b1)
                check("mem[id_pc]", bus_if.id_instr, rd(bus_if.id_pc));
        end
    end

    // One clock: drive controls, let the edge happen, then advance model and fetch.
    task automatic cycle(input logic r, input logic s, input logic f, input logic [31:0] tgt);
        logic [31:0] pc_old, a;
        rst = r;
        bus_if.stall_i = s;
        bus_if.flush_i = f;
        @(posedge clk);
        #1;
        pc_old = bus_if.if_pc;
        if (r) begin
            e_valid = 1'b0; e_pc = '0; e_pc4 = '0; e_instr = NOP_INSTR; e_busy = 1'b0;
            primed = 1'b0;
        end else if (f) begin
            e_valid = 1'b0; e_pc = pc_old; e_pc4 = pc_old + 32'd4; e_instr = NOP_INSTR;
            e_busy = 1'b0; primed = 1'b1;
        end else if (s) begin
            if (!primed) begin
                e_valid = 1'b0; e_pc = pc_old; e_pc4 = pc_old + 32'd4; e_instr = NOP_INSTR;
            end
            e_busy = primed;
        end else begin
            if (primed) begin
                e_valid = 1'b1; e_instr = rd(pc_old);
            end else begin
                e_valid = 1'b0; e_instr = NOP_INSTR;
            end
            e_pc = pc_old; e_pc4 = pc_old + 32'd4; e_busy = 1'b0; primed = 1'b1;
        end
        // Fetch unit: RAM always reads the next-PC mux, PC register honours pc_en.
        if (r) begin
            bus_if.if_pc = '0;
            bus_if.imem_rdata = $urandom;
        end else begin
            a = f ? tgt : pc_old + 32'd4;
            bus_if.imem_rdata = rd(a);
            if (!s || f) bus_if.if_pc = a;
        end
        bus_if.if_pc_add_4 = bus_if.if_pc + 32'd4;
        chk_en = 1'b1;
    endtask

    initial begin
        logic        r, s, f;
        logic [31:0] t;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[1]  = 32'h0050_0093;
        mem[4]  = 32'hAAAA_0013;
        mem[5]  = 32'hBBBB_0013;
        mem[16] = 32'h00A0_0093;
        mem[32] = 32'h1230_0093;
        bus_if.stall_i = 1'b0;
        bus_if.flush_i = 1'b0;
        bus_if.if_pc = '0;
        bus_if.if_pc_add_4 = 32'd4;
        bus_if.imem_rdata = $urandom;

        // Reset and warm-up
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst id_valid", {31'b0, bus_if.id_valid}, 32'd0);
        check("rst id_instr", bus_if.id_instr, 32'h0000_0013);
        check("rst id_pc", bus_if.id_pc, 32'd0);
        cycle(0, 0, 0, 0);
        check("warm bubble", {31'b0, bus_if.id_valid}, 32'd0);
        cycle(0, 0, 0, 0);
        check("first pc", bus_if.id_pc, 32'h4);
        check("first instr", bus_if.id_instr, 32'h0050_0093);
        check("first valid", {31'b0, bus_if.id_valid}, 32'd1);

        // Stall across a drifting RAM output
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        check("stall id_pc", bus_if.id_pc, 32'hC);
        check("stall busy", {31'b0, bus_if.hold_busy_o}, 32'd1);
        cycle(0, 0, 0, 0);
        check("release pc", bus_if.id_pc, 32'h10);
        check("release instr", bus_if.id_instr, 32'hAAAA_0013);

        // Flush from RUN
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        check("pre-flush if_pc", bus_if.if_pc, 32'h20);
        cycle(0, 0, 1, 32'h80);
        check("flush valid", {31'b0, bus_if.id_valid}, 32'd0);
        check("flush instr", bus_if.id_instr, 32'h0000_0013);
        cycle(0, 0, 0, 0);
        check("target pc", bus_if.id_pc, 32'h80);
        check("target instr", bus_if.id_instr, 32'h1230_0093);

        // Stall and flush together while holding
        cycle(0, 1, 0, 0);
        check("hold entry busy", {31'b0, bus_if.hold_busy_o}, 32'd1);
        bus_if.stall_i = 1'b1;
        bus_if.flush_i = 1'b1;
        #1;
        check("stall+flush pc_en", {31'b0, bus_if.pc_en_o}, 32'd1);
        cycle(0, 1, 1, 32'h40);
        check("stall+flush valid", {31'b0, bus_if.id_valid}, 32'd0);
        check("stall+flush busy", {31'b0, bus_if.hold_busy_o}, 32'd0);
        cycle(0, 0, 0, 0);
        check("redirect pc", bus_if.id_pc, 32'h40);
        check("redirect instr", bus_if.id_instr, 32'h00A0_0093);

        // Reset while holding, then stalled warm-up
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        check("rst-hold valid", {31'b0, bus_if.id_valid}, 32'd0);
        check("rst-hold busy", {31'b0, bus_if.hold_busy_o}, 32'd0);
        check("rst-hold pc4", bus_if.id_pc_add_4, 32'd0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("warm stall valid", {31'b0, bus_if.id_valid}, 32'd0);
        check("warm stall busy", {31'b0, bus_if.hold_busy_o}, 32'd0);
        cycle(0, 0, 0, 0);
        check("warm exit bubble", {31'b0, bus_if.id_valid}, 32'd0);
        cycle(0, 0, 0, 0);
        check("after warm pc", bus_if.id_pc, 32'h4);
        check("after warm instr", bus_if.id_instr, 32'h0050_0093);

        // Random stall/flush/reset traffic
        for (int i = 0; i < 10000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 9) < 3);
            f = ($urandom_range(0, 9) == 0);
            t = 32'($urandom_range(0, 255)) << 2;
            cycle(r, s, f, t);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
